// File: rtl/sseg_scan_pkg.sv
// Shared types and helpers for the seven-segment scan multiplexer.
//   state_e   : scan FSM states (idle / blank interval / digit on)
//   SEG_OFF   : active-low "all segments dark" pattern
//   next_en() : next enabled digit index, searching upward with wrap
package sseg_scan_pkg;

    localparam int unsigned MAX_DIG   = 16;
    localparam int unsigned IDX_MAX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } state_e;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // First enabled digit strictly after idx (mod n_dig). Returns idx itself
    // when it is the only enabled digit, or when nothing is enabled.
    function automatic logic [IDX_MAX_W-1:0] next_en(input logic [IDX_MAX_W-1:0] idx,
                                                     input logic [MAX_DIG-1:0]   dig_en,
                                                     input int unsigned          n_dig);
        logic [IDX_MAX_W-1:0] res;
        logic [IDX_MAX_W-1:0] cand4;
        logic                 found;
        int unsigned          cand;
        res   = idx;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_DIG; k++) begin
            cand  = (32'(idx) + k) % n_dig;
            cand4 = cand[IDX_MAX_W-1:0];
            if (!found && (k <= n_dig) && dig_en[cand4]) begin
                res   = cand4;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sseg_slot_timer.sv
// Digit-slot prescaler for sseg_scan_pwm.
//   clk, reset   : clock, asynchronous active-high reset
//   clr_i        : synchronous clear; holds ph at 0 while the scanner idles
//   slot_end_o   : high on the last cycle of a slot (ph == TICK_DIV-1)
//   in_blank_o   : high while ph < BLANK_CYC
//   blank_end_o  : high on the last blank cycle (ph == BLANK_CYC-1)
module sseg_slot_timer #(
    parameter int unsigned TICK_DIV  = 12500,
    parameter int unsigned BLANK_CYC = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic slot_end_o,
    output logic in_blank_o,
    output logic blank_end_o
);
    import sseg_scan_pkg::*;

    localparam int unsigned PH_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    if (BLANK_CYC >= TICK_DIV) begin : g_bad_blank
        $error("BLANK_CYC must be less than TICK_DIV");
    end

    logic [PH_W-1:0] ph_q, ph_d;
    logic            ph_last;

    always_comb begin
        ph_last     = (ph_q == PH_W'(TICK_DIV - 1));
        slot_end_o  = ph_last && !clr_i;
        in_blank_o  = (32'(ph_q) < BLANK_CYC);
        blank_end_o = (BLANK_CYC != 0) && (32'(ph_q) == BLANK_CYC - 1);
        if (clr_i || ph_last) begin
            ph_d = '0;
        end else begin
            ph_d = ph_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph_q <= '0;
        end else begin
            ph_q <= ph_d;
        end
    end

endmodule

// File: rtl/sseg_scan_pwm.sv
// Seven-segment scan multiplexer with slot blanking, PWM brightness,
// per-digit enable/skip and tear-free per-slot input latching.
//   clk, reset   : clock, asynchronous active-high reset
//   seg_in       : digit i pattern at seg_in[8i+7:8i], active-low, bit 7 = dp
//   dig_en       : 1 = digit takes part in the scan
//   brt          : brightness, 0 = dark, all-ones = full
//   blink_mask   : 1 = digit blinks (only with SSEG_SCAN_BLINK_EN)
//   an           : active-low digit enables, one-hot-low or all-ones
//   sseg         : active-low segment drive
//   frame_start  : one-cycle pulse in the first cycle of each scan frame
// Define SSEG_SCAN_BLINK_EN to build the per-digit blink feature.
module sseg_scan_pwm #(
    parameter int unsigned N_DIG        = 8,
    parameter int unsigned TICK_DIV     = 12500,
    parameter int unsigned BLANK_CYC    = 100,
    parameter int unsigned BRT_W        = 4,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [8*N_DIG-1:0] seg_in,
    input  logic [N_DIG-1:0]   dig_en,
    input  logic [BRT_W-1:0]   brt,
    input  logic [N_DIG-1:0]   blink_mask,
    output logic [N_DIG-1:0]   an,
    output logic [7:0]         sseg,
    output logic               frame_start
);
    import sseg_scan_pkg::*;

    localparam int unsigned IDX_W = $clog2(N_DIG);

    if (N_DIG < 2 || N_DIG > MAX_DIG) begin : g_bad_ndig
        $error("N_DIG must be in 2..16");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         seg_q, seg_d;
    logic [BRT_W-1:0]   brt_q, brt_d;
    logic [BRT_W-1:0]   pw_q, pw_d;
    logic [N_DIG-1:0]   an_q, an_d;
    logic [7:0]         sseg_q, sseg_d;
    logic               fs_q;

    logic               slot_end, in_blank, blank_end;
    logic               any_en, load, fs_evt, lit, blink_off;
    logic [IDX_W-1:0]   nxt_idx, first_idx, load_idx;
    logic [MAX_DIG-1:0] dig_en_ext;

    sseg_slot_timer #(
        .TICK_DIV  (TICK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (state_q == ST_IDLE),
        .slot_end_o  (slot_end),
        .in_blank_o  (in_blank),
        .blank_end_o (blank_end)
    );

    assign any_en     = |dig_en;
    assign dig_en_ext = MAX_DIG'(dig_en);
    assign nxt_idx    = IDX_W'(next_en(IDX_MAX_W'(idx_q), dig_en_ext, N_DIG));
    // Searching from the top digit wraps to the lowest enabled one.
    assign first_idx  = IDX_W'(next_en(IDX_MAX_W'(N_DIG - 1), dig_en_ext, N_DIG));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_en) state_d = (BLANK_CYC > 0) ? ST_BLANK : ST_ON;
            end
            ST_BLANK: begin
                if (blank_end) state_d = ST_ON;
            end
            ST_ON: begin
                if (slot_end) begin
                    if (!any_en)            state_d = ST_IDLE;
                    else if (BLANK_CYC > 0) state_d = ST_BLANK;
                    else                    state_d = ST_ON;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Slot-boundary latching: idx, pattern and brightness only change here,
    // so mid-slot input changes never tear the displayed digit.
    always_comb begin
        load     = 1'b0;
        load_idx = idx_q;
        fs_evt   = 1'b0;
        if (state_q == ST_IDLE) begin
            if (any_en) begin
                load     = 1'b1;
                load_idx = first_idx;
                fs_evt   = 1'b1;
            end
        end else if (slot_end && any_en) begin
            load     = 1'b1;
            load_idx = nxt_idx;
            fs_evt   = (nxt_idx <= idx_q);
        end
        idx_d = load ? load_idx : idx_q;
        seg_d = load ? seg_in[{load_idx, 3'b000} +: 8] : seg_q;
        brt_d = load ? brt : brt_q;
        // PWM phase restarts with every lit interval.
        pw_d  = (state_q != ST_ON || slot_end) ? '0 : pw_q + 1'b1;
    end

`ifdef SSEG_SCAN_BLINK_EN
    localparam int unsigned FC_W = $clog2(BLINK_FRAMES + 1);

    logic [FC_W-1:0] fc_q, fc_d;
    logic            blink_ph_q, blink_ph_d;
    logic            mask_q, mask_d;

    // fc counts frames begun in the current half-period; it starts at 0 after
    // reset so that the very first frame already belongs to the first half.
    always_comb begin
        fc_d       = fc_q;
        blink_ph_d = blink_ph_q;
        mask_d     = load ? blink_mask[load_idx] : mask_q;
        if (fs_evt) begin
            if (fc_q == FC_W'(BLINK_FRAMES)) begin
                fc_d       = FC_W'(1);
                blink_ph_d = ~blink_ph_q;
            end else begin
                fc_d = fc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fc_q       <= '0;
            blink_ph_q <= 1'b0;
            mask_q     <= 1'b0;
        end else begin
            fc_q       <= fc_d;
            blink_ph_q <= blink_ph_d;
            mask_q     <= mask_d;
        end
    end

    assign blink_off = blink_ph_q & mask_q;
`else
    logic unused_blink;
    assign unused_blink = ^blink_mask;
    assign blink_off    = 1'b0;
`endif

    // Outputs
    always_comb begin
        lit    = (brt_q == '1) || (pw_q < brt_q);
        an_d   = '1;
        sseg_d = SEG_OFF;
        // in_blank is redundant with the FSM but keeps slots strictly separated.
        if (state_q == ST_ON && !in_blank && lit && !blink_off) begin
            an_d[idx_q] = 1'b0;
            sseg_d      = seg_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q  <= '0;
            seg_q  <= SEG_OFF;
            brt_q  <= '0;
            pw_q   <= '0;
            an_q   <= '1;
            sseg_q <= SEG_OFF;
            fs_q   <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            seg_q  <= seg_d;
            brt_q  <= brt_d;
            pw_q   <= pw_d;
            an_q   <= an_d;
            sseg_q <= sseg_d;
            fs_q   <= fs_evt;
        end
    end

    assign an          = an_q;
    assign sseg        = sseg_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_sseg_scan_pwm.sv
// Directed bench for sseg_scan_pwm (N_DIG=4, TICK_DIV=20, BLANK_CYC=4, BRT_W=2,
// BLINK_FRAMES=2). Outputs are sampled on the falling clock edge.
module tb_sseg_scan_pwm;

    localparam int unsigned N_DIG        = 4;
    localparam int unsigned TICK_DIV     = 20;
    localparam int unsigned BLANK_CYC    = 4;
    localparam int unsigned BRT_W        = 2;
    localparam int unsigned BLINK_FRAMES = 2;

`ifdef SSEG_SCAN_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       seg_in;
    logic [3:0]        dig_en;
    logic [1:0]        brt;
    logic [3:0]        blink_mask;
    logic [3:0]        an;
    logic [7:0]        sseg;
    logic              frame_start;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] pats [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    always #5 clk = ~clk;

    sseg_scan_pwm #(
        .N_DIG        (N_DIG),
        .TICK_DIV     (TICK_DIV),
        .BLANK_CYC    (BLANK_CYC),
        .BRT_W        (BRT_W),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_in      (seg_in),
        .dig_en      (dig_en),
        .brt         (brt),
        .blink_mask  (blink_mask),
        .an          (an),
        .sseg        (sseg),
        .frame_start (frame_start)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Called on the falling edge of a slot's ph=0 cycle; returns on the next
    // slot's ph=0. Output lags state by one cycle, so a slot is visible at
    // ph=BLANK_CYC+1..TICK_DIV (the last being the next slot's ph=0).
    task automatic run_slot(input string tag, input int dig, input logic [7:0] pat,
                            input int nlit, input int chg_ph, input logic [7:0] chg_val,
                            input logic exp_fs);
        int         lit_cnt;
        int         bad;
        logic [3:0] on_an;
        lit_cnt    = 0;
        bad        = 0;
        on_an      = 4'hF;
        on_an[dig] = 1'b0;
        for (int ph = 1; ph <= int'(TICK_DIV); ph++) begin
            @(negedge clk);
            if (an === on_an && sseg === pat && ph > int'(BLANK_CYC)) lit_cnt++;
            else if (!(an === 4'hF && sseg === 8'hFF)) bad++;
            if (ph < int'(TICK_DIV) && frame_start !== 1'b0) bad++;
            if (ph == chg_ph) seg_in[7:0] = chg_val;
        end
        check({tag, "_lit"}, lit_cnt, nlit);
        check({tag, "_glitch"}, bad, 0);
        check({tag, "_fs"}, frame_start, exp_fs);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("fs_after_reset", frame_start, 1'b1);
    endtask

    task automatic run_frames(input string tag, input int nframes);
        int nlit;
        for (int f = 0; f < nframes; f++) begin
            for (int d = 0; d < 4; d++) begin
                nlit = (BLINK_ON && d == 1 && ((f / int'(BLINK_FRAMES)) % 2 == 1)) ? 0 : 16;
                run_slot($sformatf("%s_f%0d_d%0d", tag, f, d), d, pats[d], nlit, 0, 8'h00,
                         d == 3);
            end
        end
    endtask

    initial begin
        int bad;
        reset      = 1'b1;
        seg_in     = 32'h44332211;
        dig_en     = 4'hF;
        brt        = 2'd3;
        blink_mask = 4'b0000;

        // Reset and first slots
        repeat (3) @(negedge clk);
        check("rst_an", an, 4'hF);
        check("rst_sseg", sseg, 8'hFF);
        check("rst_fs", frame_start, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("fs_after_reset", frame_start, 1'b1);
        run_slot("s0", 0, 8'h11, 16, 0, 8'h00, 1'b0);
        run_slot("s1", 1, 8'h22, 16, 0, 8'h00, 1'b0);

        // Brightness: changes apply from the next boundary
        brt = 2'd1;
        run_slot("brt_hold", 2, 8'h33, 16, 0, 8'h00, 1'b0);
        run_slot("brt1_d3", 3, 8'h44, 4, 0, 8'h00, 1'b1);
        brt = 2'd0;
        run_slot("brt1_d0", 0, 8'h11, 4, 0, 8'h00, 1'b0);
        run_slot("brt0_d1", 1, 8'h22, 0, 0, 8'h00, 1'b0);
        brt = 2'd3;
        run_slot("brt0_d2", 2, 8'h33, 0, 0, 8'h00, 1'b0);
        run_slot("brt3_d3", 3, 8'h44, 16, 0, 8'h00, 1'b1);

        // Tear-free latch: byte 0 changes at ph=10 of the digit-0 slot
        run_slot("tear", 0, 8'h11, 16, 10, 8'h77, 1'b0);

        // Skip 0,2,0,2
        dig_en = 4'b0101;
        run_slot("skip_d1", 1, 8'h22, 16, 0, 8'h00, 1'b0);
        run_slot("skip_d2a", 2, 8'h33, 16, 0, 8'h00, 1'b1);
        run_slot("skip_d0", 0, 8'h77, 16, 0, 8'h00, 1'b0);
        run_slot("skip_d2b", 2, 8'h33, 16, 0, 8'h00, 1'b1);

        // Single digit 3
        dig_en = 4'b1000;
        run_slot("one_d0", 0, 8'h77, 16, 0, 8'h00, 1'b0);
        run_slot("one_d3a", 3, 8'h44, 16, 0, 8'h00, 1'b1);
        run_slot("one_d3b", 3, 8'h44, 16, 0, 8'h00, 1'b1);

        // Idle: current slot drains, then dark with no frame_start
        dig_en = 4'b0000;
        run_slot("idle_drain", 3, 8'h44, 16, 0, 8'h00, 1'b0);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (an !== 4'hF || sseg !== 8'hFF || frame_start !== 1'b0) bad++;
        end
        check("idle_dark", bad, 0);
        dig_en = 4'b0010;
        @(negedge clk);
        check("idle_exit_fs", frame_start, 1'b1);
        run_slot("idle_exit_d1", 1, 8'h22, 16, 0, 8'h00, 1'b1);

        // Blink (expectations fold to always-lit when the feature is not built)
        seg_in     = 32'h44332211;
        dig_en     = 4'hF;
        brt        = 2'd3;
        blink_mask = 4'b0010;
        do_reset();
        run_frames("blkA", 6);

        do_reset();
        run_frames("blkB", 3);
        run_slot("blkB_f3_d0", 0, 8'h11, 16, 0, 8'h00, 1'b0);
        repeat (10) @(negedge clk);
        check("blk_f3_d1_mid", an, BLINK_ON ? 4'hF : 4'b1101);
        #2 reset = 1'b1;
        #1;
        check("async_rst_an", an, 4'hF);
        check("async_rst_sseg", sseg, 8'hFF);
        check("async_rst_fs", frame_start, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("fs_after_async_rst", frame_start, 1'b1);
        run_frames("blkC", 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
